// File: rtl/lfsr_pkg.sv
// Definitions shared by the PRBS generator and checker: the checker FSM states
// and the default LFSR shape (x^4+x^3+1).
package lfsr_pkg;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } lfsr_state_e;

   localparam int                    LFSR_WIDTH = 4;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 4'b1100;

endpackage

// File: rtl/lfsr_next.sv
// Predicted next PRBS bit: the XOR of the register bits selected by TAPS.
// Purely combinational so the generator can reuse it unchanged.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
   input  logic [WIDTH-1:0] state_i,
   output logic             pred_o
);

   assign pred_o = ^(state_i & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds from the stream, tracks to lock, then flywheels and
// counts mispredictions. Define PRBS_CHECKER_ERR_COUNT_EN to build the error counter.
module prbs_checker
   import lfsr_pkg::*;
#(
   parameter int               WIDTH       = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(LFSR_TAPS),
   parameter int               LOCK_COUNT  = 8,
   parameter int               UNLOCK_ERRS = 3,
   parameter int               CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             din_i,
   input  logic             din_valid_i,
   input  logic             clear_err_i,
   output logic             locked_o,
   output logic             err_pulse_o,
   output logic [CNT_W-1:0] err_count_o
);

   localparam int MC_W = $clog2((LOCK_COUNT > WIDTH ? LOCK_COUNT : WIDTH) + 1);
   localparam int EC_W = $clog2(UNLOCK_ERRS + 1);

   lfsr_state_e      state_q;
   logic [WIDTH-1:0] sr_q;
   logic [MC_W-1:0]  cnt_q;
   logic [EC_W-1:0]  errs_q;
   logic             locked_q;
   logic             err_pulse_q;
   logic             pred;
   logic             mis;
   logic             zero_hit;
   logic             err_evt;

   lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next (
      .state_i (sr_q),
      .pred_o  (pred)
   );

   assign mis      = din_i ^ pred;
   // An all-zero register can never come from a real LFSR, so bail out to reseed.
   assign zero_hit = (state_q != SEED) && (sr_q == '0);
   assign err_evt  = !zero_hit && din_valid_i && (state_q == LOCKED) && mis;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= SEED;
         sr_q        <= '0;
         cnt_q       <= '0;
         errs_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= err_evt;
         if (zero_hit) begin
            state_q  <= SEED;
            cnt_q    <= '0;
            errs_q   <= '0;
            locked_q <= 1'b0;
         end else if (din_valid_i) begin
            unique case (state_q)
               SEED: begin
                  sr_q <= {sr_q[WIDTH-2:0], din_i};
                  if (cnt_q == MC_W'(WIDTH - 1)) begin
                     state_q <= TRACK;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               TRACK: begin
                  sr_q <= {sr_q[WIDTH-2:0], din_i};
                  if (mis) begin
                     cnt_q <= '0;
                  end else if (cnt_q == MC_W'(LOCK_COUNT - 1)) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     cnt_q    <= '0;
                     errs_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               LOCKED: begin
                  // Flywheel on the prediction so one bad bit costs one error.
                  sr_q <= {sr_q[WIDTH-2:0], pred};
                  if (!mis) begin
                     errs_q <= '0;
                  end else if (errs_q == EC_W'(UNLOCK_ERRS - 1)) begin
                     state_q  <= SEED;
                     locked_q <= 1'b0;
                     sr_q     <= '0;
                     cnt_q    <= '0;
                     errs_q   <= '0;
                  end else begin
                     errs_q <= errs_q + 1'b1;
                  end
               end
               default: state_q <= SEED;
            endcase
         end
      end
   end

   assign locked_o    = locked_q;
   assign err_pulse_o = err_pulse_q;

`ifdef PRBS_CHECKER_ERR_COUNT_EN
   logic [CNT_W-1:0] ecnt_q, ecnt_d;

   // Clear beats a coincident error; the counter saturates rather than wraps.
   always_comb begin
      ecnt_d = ecnt_q;
      if (clear_err_i)                  ecnt_d = '0;
      else if (err_evt && ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ecnt_q <= '0;
      else         ecnt_q <= ecnt_d;
   end

   assign err_count_o = ecnt_q;
`else
   logic unused_clr;
   assign unused_clr  = clear_err_i;
   assign err_count_o = '0;
`endif

endmodule
